// File: rtl/aes_decrypt_if.sv
// Request/result bundle for the iterative AES-128 decryptor.
// The master issues blocks and the slave returns plaintext.
interface aes_decrypt_if;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         done;
    logic         busy;

    modport master (
        output start, ciphertext, key,
        input  plaintext, done, busy
    );

    modport slave (
        input  start, ciphertext, key,
        output plaintext, done, busy
    );
endinterface

// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Round keys are re-expanded for every block before decryption.
module aes_decrypt (
    input  logic         clk,
    input  logic         reset,
    aes_decrypt_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYEXP,
        S_INIT,
        S_ROUND,
        S_FINAL
    } state_t;

    state_t       r_st;
    logic [3:0]   r_cnt;
    logic [127:0] r_state;
    logic [127:0] r_pt;
    logic         r_done;
    logic         r_busy;
    logic [127:0] r_rk [0:10];

    logic [127:0] w_isr;
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_imc;
    logic [127:0] w_nk;
    logic [7:0]   w_rcon;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse; 0 maps to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] r;
        s = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b,
                                      input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
    endfunction

    // Byte (col*4 + row) lives at bits [127-8*idx -: 8].
    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] =
                    s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                                 ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                                 ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                                 ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                                 ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k,
                                              input logic [7:0]   rc);
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])}
          ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Round constant for deriving rk[cnt+1] from rk[cnt].
    always_comb begin
        w_rcon = 8'h00;
        case (r_cnt)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Shared round datapath; the counter selects rk9..rk1, then rk0.
    always_comb begin
        w_isr = inv_shift(r_state);
        w_isb = inv_sub(w_isr);
        w_ark = w_isb ^ r_rk[r_cnt];
        w_imc = inv_mix(w_ark);
        w_nk  = key_next(r_rk[r_cnt], w_rcon);
    end

    // Round-key store: rk0 on accept, then one expansion step per cycle.
    always_ff @(posedge clk) begin
        if (r_st == S_IDLE && bus.start) begin
            r_rk[0] <= bus.key;
        end else if (r_st == S_KEYEXP) begin
            r_rk[r_cnt + 4'd1] <= w_nk;
        end
    end

    // Control FSM with registered state, result and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_st    <= S_IDLE;
            r_cnt   <= 4'd0;
            r_state <= '0;
            r_pt    <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_st)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= bus.ciphertext;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_st    <= S_KEYEXP;
                    end
                end
                S_KEYEXP: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) r_st <= S_INIT;
                end
                S_INIT: begin
                    r_state <= r_state ^ r_rk[10];
                    r_cnt   <= 4'd9;
                    r_st    <= S_ROUND;
                end
                S_ROUND: begin
                    r_state <= w_imc;
                    r_cnt   <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_st <= S_FINAL;
                end
                S_FINAL: begin
                    r_pt   <= w_ark;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_cnt  <= 4'd0;
                    r_st   <= S_IDLE;
                end
                default: r_st <= S_IDLE;
            endcase
        end
    end

    assign bus.plaintext = r_pt;
    assign bus.done      = r_done;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_aes_decrypt.sv
// Directed-vector bench for aes_decrypt.
// Known-answer blocks, latency, back-to-back, busy, reset cases.
module tb_aes_decrypt;

    logic clk = 1'b0;
    logic reset;

    aes_decrypt_if bus ();

    aes_decrypt dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K_IMG = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] C_IMG = 128'hff0b844a0853bf7c6934ab4364148fb9;
    localparam logic [127:0] P_IMG = 128'h0123456789abcdeffedcba9876543210;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the start edge.
    task automatic do_start(input logic [127:0] ct,
                            input logic [127:0] k);
        bus.start      = 1'b1;
        bus.ciphertext = ct;
        bus.key        = k;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.ciphertext = ~ct;
        bus.key        = ~k;
    endtask

    // Returns edges from start to done (-1 on timeout), busy after edge 0.
    task automatic wait_done(output int lat, output logic b0);
        lat = -1;
        b0  = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (n == 0) b0 = bus.busy;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
    endtask

    int          lat;
    int          cnt;
    logic        b0;
    logic [127:0] first_pt;

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.ciphertext = '0;
        bus.key        = '0;
        repeat (2) @(negedge clk);
        check("rst_pt", bus.plaintext, '0);
        check("rst_done", 128'(bus.done), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // FIPS-197 C.1 with exact latency
        do_start(C_C1, K_C1);
        wait_done(lat, b0);
        check("c1_busy", 128'(b0), 128'(1));
        check("c1_lat", 128'(lat), 128'(21));
        check("c1_pt", bus.plaintext, P_C1);
        check("c1_busy_done", 128'(bus.busy), 128'(0));

        // FIPS-197 appendix B
        do_start(C_B, K_B);
        wait_done(lat, b0);
        check("b_lat", 128'(lat), 128'(21));
        check("b_pt", bus.plaintext, P_B);

        // Image key, then back-to-back start in the done cycle
        do_start(C_IMG, K_IMG);
        wait_done(lat, b0);
        check("img_pt", bus.plaintext, P_IMG);
        do_start(C_C1, K_C1);
        wait_done(lat, b0);
        check("b2b_busy", 128'(b0), 128'(1));
        check("b2b_lat", 128'(lat), 128'(21));
        check("b2b_pt", bus.plaintext, P_C1);
        repeat (3) @(negedge clk);
        check("hold_pt", bus.plaintext, P_C1);
        check("hold_done", 128'(bus.done), 128'(0));

        // Start while busy is ignored
        do_start(C_B, K_B);
        repeat (5) @(negedge clk);
        do_start(C_IMG, K_IMG);
        cnt      = 0;
        first_pt = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done) begin
                if (cnt == 0) first_pt = bus.plaintext;
                cnt++;
            end
        end
        check("busy_ndone", 128'(cnt), 128'(1));
        check("busy_pt", first_pt, P_B);
        check("busy_idle", 128'(bus.busy), 128'(0));

        // Reset sampled at edge 15 aborts the block
        do_start(C_C1, K_C1);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 128'(bus.busy), 128'(0));
        check("abort_pt", bus.plaintext, '0);
        count_done(30, cnt);
        check("abort_ndone", 128'(cnt), 128'(0));
        do_start(C_C1, K_C1);
        wait_done(lat, b0);
        check("post_lat", 128'(lat), 128'(21));
        check("post_pt", bus.plaintext, P_C1);

        // Reset wins over start in the same cycle
        @(negedge clk);
        reset          = 1'b1;
        bus.start      = 1'b1;
        bus.ciphertext = C_B;
        bus.key        = K_B;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        check("coll_busy", 128'(bus.busy), 128'(0));
        check("coll_pt", bus.plaintext, '0);
        count_done(30, cnt);
        check("coll_ndone", 128'(cnt), 128'(0));
        check("coll_idle", 128'(bus.busy), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
